dcache_mshr_controller: RTL and testbench

// Non-blocking data-cache controller between the LSQ and the memory bus. Hits are

---
 rtl/dcache_mshr_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_dcache_mshr_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mshr_controller.sv
// Non-blocking data-cache controller between the LSQ and the memory bus.
// Hits are answered in the same cycle. Misses take an MSHR entry keyed by the
// memory transaction tag. A dirty victim is written back before its refill
// request is sent.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | serve hits, issue refill LOADs for clean-victim misses
// S_WB     | write the dirty victim back (bus STORE), then clean the line
// S_REFILL | victim is clean; issue the refill LOAD until it is accepted
module dcache_mshr_controller #(
    parameter int ADDR_W     = 64,
    parameter int BLOCK_W    = 64,
    parameter int INDEX_W    = 5,
    parameter int MSHR_DEPTH = 4,
    parameter int MTAG_W     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  proc_cmd,
    input  logic [ADDR_W-1:0]           proc_addr,
    input  logic [BLOCK_W-1:0]          proc_wdata,
    input  logic                        cm_hit,
    input  logic [BLOCK_W-1:0]          cm_rdata,
    input  logic                        cm_victim_dirty,
    input  logic [ADDR_W-INDEX_W-4:0]   cm_victim_tag,
    output logic [1:0]                  mem_cmd,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [BLOCK_W-1:0]          mem_wdata,
    input  logic [MTAG_W-1:0]           mem_response,
    input  logic [MTAG_W-1:0]           mem_tag,
    input  logic [BLOCK_W-1:0]          mem_rdata,
    output logic                        cm_wr_en,
    output logic [INDEX_W-1:0]          cm_wr_index,
    output logic [ADDR_W-INDEX_W-4:0]   cm_wr_tag,
    output logic [BLOCK_W-1:0]          cm_wr_data,
    output logic                        cm_wr_dirty,
    output logic                        resp_valid,
    output logic [BLOCK_W-1:0]          resp_data,
    output logic [ADDR_W-1:0]           resp_addr,
    output logic                        stall
);

    localparam int BLK_W = ADDR_W - 3;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

    state_t state_q, state_d;

    logic [MSHR_DEPTH-1:0] valid_q;
    logic [MTAG_W-1:0]     mtag_q  [MSHR_DEPTH];
    logic [BLK_W-1:0]      blk_q   [MSHR_DEPTH];
    logic                  store_q [MSHR_DEPTH];
    logic [BLOCK_W-1:0]    sdata_q [MSHR_DEPTH];

    logic                  req;
    logic [BLK_W-1:0]      req_blk;
    logic [INDEX_W-1:0]    req_index;

    logic                  fill_hit;
    logic [MSHR_DEPTH-1:0] fill_oh;
    logic                  fill_store;
    logic [BLOCK_W-1:0]    fill_sdata;
    logic [BLK_W-1:0]      fill_blk;

    logic                  free_found;
    logic [MSHR_DEPTH-1:0] free_oh;
    logic                  pend_match;
    logic                  alloc;

    // Byte offset within the 8-byte block never reaches the bus or the MSHRs.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^proc_addr[2:0];

    assign req       = (proc_cmd == CMD_LOAD) || (proc_cmd == CMD_STORE);
    assign req_blk   = proc_addr[ADDR_W-1:3];
    assign req_index = proc_addr[INDEX_W+2:3];

    // MSHR lookups: completing entry, lowest free entry, pending same-block miss.
    always_comb begin
        fill_hit   = 1'b0;
        fill_oh    = '0;
        fill_store = 1'b0;
        fill_sdata = '0;
        fill_blk   = '0;
        free_found = 1'b0;
        free_oh    = '0;
        pend_match = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (!fill_hit && valid_q[i] && (mem_tag != '0) && (mtag_q[i] == mem_tag)) begin
                fill_hit   = 1'b1;
                fill_oh[i] = 1'b1;
                fill_store = store_q[i];
                fill_sdata = sdata_q[i];
                fill_blk   = blk_q[i];
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_oh[i] = 1'b1;
            end
            if (valid_q[i] && (blk_q[i] == req_blk)) begin
                pend_match = 1'b1;
            end
        end
    end

    // Output decode and next state; a fill owns the write port and blocks everything else.
    always_comb begin
        state_d     = state_q;
        alloc       = 1'b0;
        mem_cmd     = CMD_NONE;
        mem_addr    = '0;
        mem_wdata   = '0;
        cm_wr_en    = 1'b0;
        cm_wr_index = '0;
        cm_wr_tag   = '0;
        cm_wr_data  = '0;
        cm_wr_dirty = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_addr   = '0;
        stall       = 1'b0;
        if (!reset) begin
            if (fill_hit) begin
                cm_wr_en    = 1'b1;
                cm_wr_index = fill_blk[INDEX_W-1:0];
                cm_wr_tag   = fill_blk[BLK_W-1:INDEX_W];
                cm_wr_data  = fill_store ? fill_sdata : mem_rdata;
                cm_wr_dirty = fill_store;
                if (!fill_store) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_rdata;
                    resp_addr  = {fill_blk, 3'b000};
                end
                stall = req;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req) begin
                            if (cm_hit) begin
                                if (proc_cmd == CMD_LOAD) begin
                                    resp_valid = 1'b1;
                                    resp_data  = cm_rdata;
                                    resp_addr  = {req_blk, 3'b000};
                                end else begin
                                    cm_wr_en    = 1'b1;
                                    cm_wr_index = req_index;
                                    cm_wr_tag   = req_blk[BLK_W-1:INDEX_W];
                                    cm_wr_data  = proc_wdata;
                                    cm_wr_dirty = 1'b1;
                                end
                            end else if (pend_match || !free_found) begin
                                stall = 1'b1;
                            end else if (cm_victim_dirty) begin
                                stall   = 1'b1;
                                state_d = S_WB;
                            end else begin
                                mem_cmd  = CMD_LOAD;
                                mem_addr = {req_blk, 3'b000};
                                if (mem_response != '0) begin
                                    alloc = 1'b1;
                                end else begin
                                    stall = 1'b1;
                                end
                            end
                        end
                    end
                    S_WB: begin
                        stall     = 1'b1;
                        mem_cmd   = CMD_STORE;
                        mem_addr  = {cm_victim_tag, req_index, 3'b000};
                        mem_wdata = cm_rdata;
                        if (mem_response != '0) begin
                            cm_wr_en    = 1'b1;
                            cm_wr_index = req_index;
                            cm_wr_tag   = cm_victim_tag;
                            cm_wr_data  = cm_rdata;
                            cm_wr_dirty = 1'b0;
                            state_d     = S_REFILL;
                        end
                    end
                    S_REFILL: begin
                        stall    = 1'b1;
                        mem_cmd  = CMD_LOAD;
                        mem_addr = {req_blk, 3'b000};
                        if (mem_response != '0) begin
                            alloc   = 1'b1;
                            stall   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // FSM state and MSHR table; only valid bits need clearing on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if (fill_oh[i]) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc && free_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    mtag_q[i]  <= mem_response;
                    blk_q[i]   <= req_blk;
                    store_q[i] <= (proc_cmd == CMD_STORE);
                    sdata_q[i] <= proc_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_mshr_controller.sv
// Directed bench for dcache_mshr_controller. Load responses are checked through
// an address-keyed scoreboard; bus and write-port behaviour is checked inline.
module tb_dcache_mshr_controller;

    logic          clock;
    logic          reset;
    logic [1:0]    proc_cmd;
    logic [63:0]   proc_addr;
    logic [63:0]   proc_wdata;
    logic          cm_hit;
    logic [63:0]   cm_rdata;
    logic          cm_victim_dirty;
    logic [55:0]   cm_victim_tag;
    logic [1:0]    mem_cmd;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic [3:0]    mem_response;
    logic [3:0]    mem_tag;
    logic [63:0]   mem_rdata;
    logic          cm_wr_en;
    logic [4:0]    cm_wr_index;
    logic [55:0]   cm_wr_tag;
    logic [63:0]   cm_wr_data;
    logic          cm_wr_dirty;
    logic          resp_valid;
    logic [63:0]   resp_data;
    logic [63:0]   resp_addr;
    logic          stall;

    dcache_mshr_controller dut (
        .clock           (clock),
        .reset           (reset),
        .proc_cmd        (proc_cmd),
        .proc_addr       (proc_addr),
        .proc_wdata      (proc_wdata),
        .cm_hit          (cm_hit),
        .cm_rdata        (cm_rdata),
        .cm_victim_dirty (cm_victim_dirty),
        .cm_victim_tag   (cm_victim_tag),
        .mem_cmd         (mem_cmd),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_response    (mem_response),
        .mem_tag         (mem_tag),
        .mem_rdata       (mem_rdata),
        .cm_wr_en        (cm_wr_en),
        .cm_wr_index     (cm_wr_index),
        .cm_wr_tag       (cm_wr_tag),
        .cm_wr_data      (cm_wr_data),
        .cm_wr_dirty     (cm_wr_dirty),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_addr       (resp_addr),
        .stall           (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    passed = 0;
    int    failed = 0;
    int    total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_resp(input logic [63:0] a, input logic [63:0] d);
        resp_t r;
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
    endtask

    task automatic clr();
        proc_cmd        = 2'd0;
        proc_addr       = '0;
        proc_wdata      = '0;
        cm_hit          = 1'b0;
        cm_rdata        = '0;
        cm_victim_dirty = 1'b0;
        cm_victim_tag   = '0;
        mem_response    = '0;
        mem_tag         = '0;
        mem_rdata       = '0;
    endtask

    // Advance to just after the next rising edge with all inputs idle.
    task automatic next();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic look();
        #1;
    endtask

    task automatic miss_load(input logic [63:0] a, input logic [3:0] rsp);
        proc_cmd     = 2'd1;
        proc_addr    = a;
        mem_response = rsp;
    endtask

    task automatic fill(input logic [3:0] t, input logic [63:0] d);
        mem_tag   = t;
        mem_rdata = d;
    endtask

    // Scoreboard: every response must match an outstanding expectation by address.
    always @(negedge clock) begin
        int k;
        if (resp_valid === 1'b1) begin
            k = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (k < 0 && exp_q[i].addr == resp_addr) k = i;
            end
            total++;
            assert (k >= 0) passed++;
            else begin
                failed++;
                $error("FAIL resp_unexpected: observed addr=%0h data=%0h expected no response", resp_addr, resp_data);
            end
            if (k >= 0) begin
                chk("resp_data", resp_data, exp_q[k].data);
                exp_q.delete(k);
            end
        end
    end

    initial begin
        clr();
        reset = 1'b1;
        proc_cmd = 2'd1;
        cm_hit   = 1'b1;
        cm_rdata = 64'hDEAD;
        @(posedge clock);
        #1;
        look();
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_cmd", mem_cmd, 2'd0);
        chk("rst_wr_en", cm_wr_en, 1'b0);

        // Load hit and store hit
        next();
        reset     = 1'b0;
        proc_cmd  = 2'd1;
        proc_addr = 64'h0000_0000_0000_0500;
        cm_hit    = 1'b1;
        cm_rdata  = 64'hDEAD;
        expect_resp(64'h500, 64'hDEAD);
        look();
        chk("hit_ld_stall", stall, 1'b0);
        chk("hit_ld_valid", resp_valid, 1'b1);
        next();
        proc_cmd   = 2'd2;
        proc_addr  = 64'h5010;
        proc_wdata = 64'h77;
        cm_hit     = 1'b1;
        look();
        chk("hit_st_wr_en", cm_wr_en, 1'b1);
        chk("hit_st_dirty", cm_wr_dirty, 1'b1);
        chk("hit_st_data", cm_wr_data, 64'h77);
        chk("hit_st_index", cm_wr_index, 5'd2);
        chk("hit_st_stall", stall, 1'b0);

        // Clean load miss at 0x1000, tag 3
        next();
        miss_load(64'h1000, 4'd3);
        expect_resp(64'h1000, 64'h55);
        look();
        chk("miss_mem_cmd", mem_cmd, 2'd1);
        chk("miss_mem_addr", mem_addr, 64'h1000);
        chk("miss_stall", stall, 1'b0);
        next();
        miss_load(64'h1000, 4'd4);
        look();
        chk("same_blk_stall", stall, 1'b1);
        chk("same_blk_no_cmd", mem_cmd, 2'd0);
        next();
        next();
        next();
        fill(4'd3, 64'h55);
        look();
        chk("fill_wr_en", cm_wr_en, 1'b1);
        chk("fill_dirty", cm_wr_dirty, 1'b0);
        chk("fill_data", cm_wr_data, 64'h55);
        chk("fill_index", cm_wr_index, 5'd0);
        chk("fill_tag", cm_wr_tag, 56'h10);
        chk("fill_resp_valid", resp_valid, 1'b1);
        next();
        fill(4'd3, 64'h66);
        look();
        chk("stale_tag_no_wr", cm_wr_en, 1'b0);

        // Store miss with dirty victim tag 0x7
        next();
        proc_cmd = 2'd2; proc_addr = 64'h2008; proc_wdata = 64'hBEEF;
        cm_victim_dirty = 1'b1; cm_victim_tag = 56'h7; cm_rdata = 64'h99;
        look();
        chk("wb_enter_stall", stall, 1'b1);
        chk("wb_enter_no_cmd", mem_cmd, 2'd0);
        next();
        proc_cmd = 2'd2; proc_addr = 64'h2008; proc_wdata = 64'hBEEF;
        cm_victim_dirty = 1'b1; cm_victim_tag = 56'h7; cm_rdata = 64'h99;
        mem_response = 4'd5;
        look();
        chk("wb_mem_cmd", mem_cmd, 2'd2);
        chk("wb_mem_addr", mem_addr, 64'h708);
        chk("wb_mem_wdata", mem_wdata, 64'h99);
        chk("wb_clean_wr_en", cm_wr_en, 1'b1);
        chk("wb_clean_dirty", cm_wr_dirty, 1'b0);
        chk("wb_clean_tag", cm_wr_tag, 56'h7);
        chk("wb_stall", stall, 1'b1);
        next();
        proc_cmd = 2'd2; proc_addr = 64'h2008; proc_wdata = 64'hBEEF;
        cm_victim_tag = 56'h7; cm_rdata = 64'h99;
        mem_response = 4'd6;
        look();
        chk("refill_mem_cmd", mem_cmd, 2'd1);
        chk("refill_mem_addr", mem_addr, 64'h2008);
        chk("refill_stall", stall, 1'b0);
        next();
        next();
        fill(4'd6, 64'h1234);
        look();
        chk("st_fill_wr_en", cm_wr_en, 1'b1);
        chk("st_fill_data", cm_wr_data, 64'hBEEF);
        chk("st_fill_dirty", cm_wr_dirty, 1'b1);
        chk("st_fill_tag", cm_wr_tag, 56'h20);
        chk("st_fill_index", cm_wr_index, 5'd1);
        chk("st_fill_no_resp", resp_valid, 1'b0);

        // Fill the MSHR table, then a fifth miss must wait
        for (int t = 1; t <= 4; t++) begin
            next();
            miss_load(64'h3000 + 64'((t - 1) * 8), 4'(t));
            expect_resp(64'h3000 + 64'((t - 1) * 8), 64'hA0 + 64'(t));
            look();
            chk("alloc_stall", stall, 1'b0);
        end
        for (int c = 0; c < 2; c++) begin
            next();
            miss_load(64'h3020, 4'd5);
            look();
            chk("full_stall", stall, 1'b1);
            chk("full_no_cmd", mem_cmd, 2'd0);
        end
        next();
        miss_load(64'h3020, 4'd0);
        fill(4'd2, 64'hA2);
        look();
        chk("fill_pri_stall", stall, 1'b1);
        chk("fill_pri_no_cmd", mem_cmd, 2'd0);
        chk("fill_pri_wr_en", cm_wr_en, 1'b1);
        next();
        miss_load(64'h3020, 4'd7);
        expect_resp(64'h3020, 64'hB7);
        look();
        chk("freed_mem_cmd", mem_cmd, 2'd1);
        chk("freed_stall", stall, 1'b0);
        next(); fill(4'd1, 64'hA1);
        next(); fill(4'd3, 64'hA3);
        next(); fill(4'd4, 64'hA4);
        next(); fill(4'd7, 64'hB7);
        next();
        look();
        chk("drained_q", 64'(exp_q.size()), 64'd0);

        // Rejected requests are retried each cycle without allocating
        for (int c = 0; c < 3; c++) begin
            next();
            miss_load(64'h4000, 4'd0);
            look();
            chk("rej_mem_cmd", mem_cmd, 2'd1);
            chk("rej_stall", stall, 1'b1);
        end
        next();
        miss_load(64'h4000, 4'd8);
        look();
        chk("accept_stall", stall, 1'b0);
        next();
        fill(4'd0, 64'h0);
        mem_tag = 4'd0;
        next();
        miss_load(64'h4008, 4'd9);
        look();
        chk("second_alloc_stall", stall, 1'b0);

        // Reset with two live MSHRs; old tags must be ignored afterwards
        next();
        reset = 1'b1;
        fill(4'd8, 64'hC8);
        look();
        chk("midrst_wr_en", cm_wr_en, 1'b0);
        chk("midrst_resp", resp_valid, 1'b0);
        next();
        reset = 1'b0;
        fill(4'd8, 64'hC8);
        look();
        chk("old_tag8_wr_en", cm_wr_en, 1'b0);
        chk("old_tag8_resp", resp_valid, 1'b0);
        next();
        fill(4'd9, 64'hC9);
        look();
        chk("old_tag9_wr_en", cm_wr_en, 1'b0);
        next();
        miss_load(64'h6000, 4'd1);
        expect_resp(64'h6000, 64'hE1);
        look();
        chk("post_rst_mem_cmd", mem_cmd, 2'd1);
        chk("post_rst_stall", stall, 1'b0);
        next();
        fill(4'd1, 64'hE1);
        look();
        chk("post_rst_fill", cm_wr_en, 1'b1);
        next();
        next();
        look();
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
